// File: rtl/tsi_command_engine.sv
`default_nettype none
// ============================================================================
// Module   : tsi_command_engine
// Purpose  : Target-side TSI protocol engine. Parses the 32-bit host word
//            stream (CMD, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, data...) into
//            single-beat 32-bit memory reads/writes and streams read data
//            back to the host. One memory access outstanding at a time.
// Ports    : clock, reset          - clock, synchronous active-high reset
//            host_in_*             - host->target word stream (valid/ready)
//            host_out_*            - target->host word stream (registered)
//            mem_req_*             - memory request (write=1 / read=0)
//            mem_resp_*            - memory read data (reads only)
//            busy                  - packet in progress or word pending
//            err                   - sticky illegal-command flag
// Options  : TSI_ENGINE_ERR_EN     - when defined, CMD words > 1 set err and
//                                    the packet header is discarded.
// Revision : 1.0 - initial release
// ============================================================================
module tsi_command_engine #(
   parameter int ADDR_BITS = 64,
   parameter int LEN_BITS  = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 host_in_valid,
   output logic                 host_in_ready,
   input  logic [31:0]          host_in_bits,
   output logic                 host_out_valid,
   input  logic                 host_out_ready,
   output logic [31:0]          host_out_bits,
   output logic                 mem_req_valid,
   input  logic                 mem_req_ready,
   output logic                 mem_req_write,
   output logic [ADDR_BITS-1:0] mem_req_addr,
   output logic [31:0]          mem_req_data,
   input  logic                 mem_resp_valid,
   output logic                 mem_resp_ready,
   input  logic [31:0]          mem_resp_data,
   output logic                 busy,
   output logic                 err
);

   typedef enum logic [2:0] {
      S_CMD     = 3'd0,
      S_ADDR_LO = 3'd1,
      S_ADDR_HI = 3'd2,
      S_LEN_LO  = 3'd3,
      S_LEN_HI  = 3'd4,
      S_WR_DATA = 3'd5,
      S_RD_REQ  = 3'd6,
      S_RD_RESP = 3'd7
   } state_t;

   localparam logic [ADDR_BITS-1:0] c_ADDR_STEP = ADDR_BITS'(4);
   localparam logic [LEN_BITS-1:0]  c_LEN_ONE   = LEN_BITS'(1);

   state_t                r_state, w_state_next;
   logic                  r_is_write;
   logic                  r_discard;
   logic [31:0]           r_addr_lo;
   logic [ADDR_BITS-1:0]  r_addr;
   logic [LEN_BITS-1:0]   r_remaining;
   logic                  r_out_valid;
   logic [31:0]           r_out_bits;

   logic                  w_in_fire, w_req_fire, w_resp_fire, w_out_fire;
   logic                  w_last;
   logic                  w_cmd_illegal;
   logic [63:0]           w_addr_asm;

   assign w_in_fire   = host_in_valid & host_in_ready;
   assign w_req_fire  = mem_req_valid & mem_req_ready;
   assign w_resp_fire = mem_resp_valid & mem_resp_ready;
   assign w_out_fire  = r_out_valid & host_out_ready;
   assign w_last      = (r_remaining == '0);
   // Full 64-bit address assembled as the high word arrives; truncated below.
   assign w_addr_asm  = {host_in_bits, r_addr_lo};

`ifdef TSI_ENGINE_ERR_EN
   logic r_err;
   assign w_cmd_illegal = (host_in_bits > 32'd1);
   assign err           = r_err;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if (r_state == S_CMD && w_in_fire && w_cmd_illegal) begin
         r_err <= 1'b1;
      end
   end
`else
   assign w_cmd_illegal = 1'b0;
   assign err           = 1'b0;
`endif

   assign mem_req_addr   = r_addr;
   assign host_out_valid = r_out_valid;
   assign host_out_bits  = r_out_bits;
   assign busy           = (r_state != S_CMD) | r_out_valid;

   always_comb begin
      w_state_next   = r_state;
      host_in_ready  = 1'b0;
      mem_req_valid  = 1'b0;
      mem_req_write  = 1'b0;
      mem_req_data   = 32'd0;
      mem_resp_ready = 1'b0;
      case (r_state)
         S_CMD: begin
            host_in_ready = 1'b1;
            if (w_in_fire) w_state_next = S_ADDR_LO;
         end
         S_ADDR_LO: begin
            host_in_ready = 1'b1;
            if (w_in_fire) w_state_next = S_ADDR_HI;
         end
         S_ADDR_HI: begin
            host_in_ready = 1'b1;
            if (w_in_fire) w_state_next = S_LEN_LO;
         end
         S_LEN_LO: begin
            host_in_ready = 1'b1;
            if (w_in_fire) w_state_next = S_LEN_HI;
         end
         S_LEN_HI: begin
            // LEN_HI is consumed but never affects the beat count.
            host_in_ready = 1'b1;
            if (w_in_fire) begin
               if (r_discard)       w_state_next = S_CMD;
               else if (r_is_write) w_state_next = S_WR_DATA;
               else                 w_state_next = S_RD_REQ;
            end
         end
         S_WR_DATA: begin
            // Host word goes straight through to memory; backpressure is
            // handed back to the host unchanged.
            mem_req_valid = host_in_valid;
            host_in_ready = mem_req_ready;
            mem_req_write = 1'b1;
            mem_req_data  = host_in_bits;
            if (w_req_fire && w_last) w_state_next = S_CMD;
         end
         S_RD_REQ: begin
            mem_req_valid = 1'b1;
            if (w_req_fire) w_state_next = S_RD_RESP;
         end
         S_RD_RESP: begin
            // Only accept read data when the output slot is free.
            mem_resp_ready = ~r_out_valid;
            if (w_resp_fire) w_state_next = w_last ? S_CMD : S_RD_REQ;
         end
         default: w_state_next = S_CMD;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_CMD;
         r_is_write  <= 1'b0;
         r_discard   <= 1'b0;
         r_addr_lo   <= 32'd0;
         r_addr      <= '0;
         r_remaining <= '0;
         r_out_valid <= 1'b0;
         r_out_bits  <= 32'd0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            S_CMD: if (w_in_fire) begin
               r_is_write <= host_in_bits[0];
               r_discard  <= w_cmd_illegal;
            end
            S_ADDR_LO: if (w_in_fire) r_addr_lo <= host_in_bits;
            S_ADDR_HI: if (w_in_fire) r_addr <= w_addr_asm[ADDR_BITS-1:0];
            S_LEN_LO:  if (w_in_fire) r_remaining <= host_in_bits[LEN_BITS-1:0];
            S_WR_DATA: if (w_req_fire) begin
               r_addr <= r_addr + c_ADDR_STEP;
               if (!w_last) r_remaining <= r_remaining - c_LEN_ONE;
            end
            S_RD_RESP: if (w_resp_fire) begin
               r_addr <= r_addr + c_ADDR_STEP;
               if (!w_last) r_remaining <= r_remaining - c_LEN_ONE;
            end
            default: ;
         endcase
         // A reload in the same cycle as a drain keeps the slot full.
         if (w_resp_fire) begin
            r_out_valid <= 1'b1;
            r_out_bits  <= mem_resp_data;
         end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tsi_command_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_tsi_command_engine
// Purpose  : Self-checking bench for tsi_command_engine. Table of packets
//            with expected memory traffic / host words, plus hand sequences
//            for reset behaviour. Memory and host sink are modelled here.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tsi_command_engine;

   logic        clock = 1'b0;
   logic        reset;
   logic        host_in_valid, host_in_ready;
   logic [31:0] host_in_bits;
   logic        host_out_valid, host_out_ready;
   logic [31:0] host_out_bits;
   logic        mem_req_valid, mem_req_ready, mem_req_write;
   logic [63:0] mem_req_addr;
   logic [31:0] mem_req_data;
   logic        mem_resp_valid, mem_resp_ready;
   logic [31:0] mem_resp_data;
   logic        busy, err;

   tsi_command_engine #(.ADDR_BITS(64), .LEN_BITS(32)) dut (
      .clock(clock), .reset(reset),
      .host_in_valid(host_in_valid), .host_in_ready(host_in_ready), .host_in_bits(host_in_bits),
      .host_out_valid(host_out_valid), .host_out_ready(host_out_ready), .host_out_bits(host_out_bits),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
      .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_data(mem_resp_data),
      .busy(busy), .err(err)
   );

   always #5 clock = ~clock;

   // kind: 0 = write packet, 1 = read packet, 2 = discarded packet
   typedef struct packed {
      logic [1:0]        kind;
      logic [31:0]       cmd;
      logic [63:0]       addr;
      logic [31:0]       len;
      logic [2:0]        nexp;
      logic [3:0][63:0]  exp_addr;
      logic [3:0][31:0]  dat;      // write data sent, or expected host_out words
      logic              rdy_mode; // 0 = mem_req_ready high, 1 = toggling
      logic [7:0]        hold;     // cycles host_out_ready is held low
      logic              exp_err;
   } vec_t;

   localparam int c_NVEC = 8;
   vec_t vecs [c_NVEC];

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [95:0] wr_q [$];
   logic [63:0] rd_q [$];
   logic [31:0] out_q [$];
   logic [31:0] mem [logic [63:0]];
   logic        in_wr;
   logic        rdy_mode;
   int          hold_cnt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got an event, expected none", name);
   endtask

   // Arrays are packed, so element [0] is the rightmost in each literal.
   function automatic vec_t mk(input logic [1:0] kind, input logic [31:0] cmd,
                               input logic [63:0] addr, input logic [31:0] len,
                               input logic [2:0] nexp, input logic [3:0][63:0] a,
                               input logic [3:0][31:0] d, input logic rdy,
                               input logic [7:0] hold, input logic e);
      vec_t v;
      v.kind = kind; v.cmd = cmd; v.addr = addr; v.len = len; v.nexp = nexp;
      v.exp_addr = a; v.dat = d; v.rdy_mode = rdy; v.hold = hold; v.exp_err = e;
      return v;
   endfunction

   // Memory model, host sink and running protocol checks.
   initial begin : g_monitor
      logic        s_rd, s_resp, s_ov;
      logic [63:0] rd_addr;
      logic [95:0] e;
      logic [63:0] ea;
      logic [31:0] ed;
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'd0;
      host_out_ready = 1'b1;
      rd_addr        = 64'd0;
      forever begin
         @(negedge clock);
         s_rd = 1'b0; s_resp = 1'b0; s_ov = host_out_valid;
         if (!reset) begin
            if (mem_req_valid && mem_req_ready) begin
               if (mem_req_write) begin
                  if (wr_q.size() == 0) unexpected("mem_write");
                  else begin
                     e = wr_q.pop_front();
                     check("wr_addr", mem_req_addr, e[95:32]);
                     check("wr_data", {32'd0, mem_req_data}, {32'd0, e[31:0]});
                  end
                  mem[mem_req_addr] = mem_req_data;
               end else begin
                  if (rd_q.size() == 0) unexpected("mem_read");
                  else begin
                     ea = rd_q.pop_front();
                     check("rd_addr", mem_req_addr, ea);
                  end
                  s_rd = 1'b1;
                  rd_addr = mem_req_addr;
               end
            end
            if (mem_resp_valid && mem_resp_ready) s_resp = 1'b1;
            if (host_out_valid && host_out_ready) begin
               if (out_q.size() == 0) unexpected("host_out");
               else begin
                  ed = out_q.pop_front();
                  check("host_out", {32'd0, host_out_bits}, {32'd0, ed});
               end
            end
            if (host_out_valid) check("resp_ready_held", {63'd0, mem_resp_ready}, 64'd0);
            if (in_wr && host_in_valid)
               check("in_ready_tracks", {63'd0, host_in_ready}, {63'd0, mem_req_ready});
         end
         @(posedge clock); #1;
         if (s_resp || reset) mem_resp_valid = 1'b0;
         if (s_rd) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem.exists(rd_addr) ? mem[rd_addr] : ~rd_addr[31:0];
         end
         mem_req_ready = rdy_mode ? ~mem_req_ready : 1'b1;
         if (s_ov && hold_cnt > 0) hold_cnt--;
         host_out_ready = (hold_cnt == 0);
      end
   end

   task automatic send_word(input logic [31:0] w);
      int t;
      bit done;
      t = 0; done = 1'b0;
      host_in_valid = 1'b1;
      host_in_bits  = w;
      while (!done) begin
         @(negedge clock);
         if (host_in_ready) done = 1'b1;
         @(posedge clock); #1;
         t++;
         if (!done && t > 300) begin
            check("host_in_accept_timeout", 64'd0, 64'd1);
            done = 1'b1;
         end
      end
      host_in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      bit ok;
      t = 0; ok = 1'b0;
      while (!ok && t < 400) begin
         @(negedge clock);
         if (!busy && !mem_resp_valid && wr_q.size() == 0 && rd_q.size() == 0 && out_q.size() == 0)
            ok = 1'b1;
         t++;
      end
      check("idle_reached", {63'd0, ok}, 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_req_valid"},  {63'd0, mem_req_valid},  64'd0);
      check({tag, "_mem_req_write"},  {63'd0, mem_req_write},  64'd0);
      check({tag, "_mem_req_addr"},   mem_req_addr,            64'd0);
      check({tag, "_mem_req_data"},   {32'd0, mem_req_data},   64'd0);
      check({tag, "_host_out_valid"}, {63'd0, host_out_valid}, 64'd0);
      check({tag, "_host_out_bits"},  {32'd0, host_out_bits},  64'd0);
      check({tag, "_mem_resp_ready"}, {63'd0, mem_resp_ready}, 64'd0);
      check({tag, "_busy"},           {63'd0, busy},           64'd0);
      check({tag, "_err"},            {63'd0, err},            64'd0);
   endtask

   task automatic run_packet(input vec_t v);
      rdy_mode = v.rdy_mode;
      hold_cnt = int'(v.hold);
      for (int j = 0; j < int'(v.nexp); j++) begin
         if (v.kind == 2'd0) wr_q.push_back({v.exp_addr[j], v.dat[j]});
         if (v.kind == 2'd1) begin
            rd_q.push_back(v.exp_addr[j]);
            out_q.push_back(v.dat[j]);
         end
      end
      send_word(v.cmd);
      send_word(v.addr[31:0]);
      send_word(v.addr[63:32]);
      send_word(v.len);
      send_word(32'h0);
      if (v.kind == 2'd0) begin
         in_wr = 1'b1;
         for (int j = 0; j < int'(v.nexp); j++) send_word(v.dat[j]);
         in_wr = 1'b0;
      end
      wait_idle();
      check("err", {63'd0, err}, {63'd0, v.exp_err});
      @(posedge clock); #1;
   endtask

   initial begin : g_main
      logic c_err;
`ifdef TSI_ENGINE_ERR_EN
      c_err = 1'b1;
`else
      c_err = 1'b0;
`endif
      reset = 1'b1; host_in_valid = 1'b0; host_in_bits = 32'd0;
      in_wr = 1'b0; rdy_mode = 1'b0; hold_cnt = 0;

      vecs[0] = mk(2'd0, 32'd1, 64'h0000_0000_8000_0000, 32'd1, 3'd2,
                   {64'h0, 64'h0, 64'h8000_0004, 64'h8000_0000},
                   {32'h0, 32'h0, 32'h1234_5678, 32'hDEAD_BEEF}, 1'b0, 8'd0, 1'b0);
      vecs[1] = mk(2'd1, 32'd0, 64'h0000_0000_8000_0000, 32'd1, 3'd2,
                   {64'h0, 64'h0, 64'h8000_0004, 64'h8000_0000},
                   {32'h0, 32'h0, 32'h1234_5678, 32'hDEAD_BEEF}, 1'b0, 8'd0, 1'b0);
      vecs[2] = mk(2'd0, 32'd1, 64'h1000, 32'd3, 3'd4,
                   {64'h100C, 64'h1008, 64'h1004, 64'h1000},
                   {32'hA300_0003, 32'hA200_0002, 32'hA100_0001, 32'hA000_0000}, 1'b1, 8'd0, 1'b0);
      vecs[3] = mk(2'd1, 32'd0, 64'h1000, 32'd3, 3'd4,
                   {64'h100C, 64'h1008, 64'h1004, 64'h1000},
                   {32'hA300_0003, 32'hA200_0002, 32'hA100_0001, 32'hA000_0000}, 1'b0, 8'd10, 1'b0);
      vecs[4] = mk(2'd0, 32'd1, 64'hFFFF_FFFF_FFFF_FFFC, 32'd1, 3'd2,
                   {64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC},
                   {32'h0, 32'h0, 32'h6666_6666, 32'h5555_5555}, 1'b0, 8'd0, 1'b0);
      vecs[5] = mk(2'd1, 32'd0, 64'hFFFF_FFFF_FFFF_FFFC, 32'd1, 3'd2,
                   {64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC},
                   {32'h0, 32'h0, 32'h6666_6666, 32'h5555_5555}, 1'b0, 8'd3, 1'b0);
`ifdef TSI_ENGINE_ERR_EN
      vecs[6] = mk(2'd2, 32'd7, 64'h2000, 32'd0, 3'd0, '0, '0, 1'b0, 8'd0, c_err);
`else
      vecs[6] = mk(2'd0, 32'd7, 64'h2000, 32'd0, 3'd1, {64'h0, 64'h0, 64'h0, 64'h2000},
                   {32'h0, 32'h0, 32'h0, 32'h7777_7777}, 1'b0, 8'd0, c_err);
`endif
      vecs[7] = mk(2'd1, 32'd0, 64'h8000_0000, 32'd0, 3'd1, {64'h0, 64'h0, 64'h0, 64'h8000_0000},
                   {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF}, 1'b0, 8'd0, c_err);

      repeat (3) @(posedge clock);
      #1;
      @(negedge clock);
      check_reset_outputs("por");
      @(posedge clock); #1;
      reset = 1'b0;

      for (int i = 0; i < c_NVEC; i++) run_packet(vecs[i]);

      // Reset while a write packet is mid-data: one beat lands, rest abandoned.
      rdy_mode = 1'b0;
      hold_cnt = 0;
      wr_q.push_back({64'h3000, 32'hC0FF_EE00});
      send_word(32'd1);
      send_word(32'h3000);
      send_word(32'h0);
      send_word(32'd3);
      send_word(32'h0);
      in_wr = 1'b1;
      send_word(32'hC0FF_EE00);
      in_wr = 1'b0;
      @(negedge clock);
      check("busy_mid_write", {63'd0, busy}, 64'd1);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
      check_reset_outputs("midrst");
      @(posedge clock); #1;
      reset = 1'b0;
      run_packet(mk(2'd1, 32'd0, 64'h3000, 32'd0, 3'd1, {64'h0, 64'h0, 64'h0, 64'h3000},
                    {32'h0, 32'h0, 32'h0, 32'hC0FF_EE00}, 1'b0, 8'd2, 1'b0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : g_watchdog
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
